matrix_row_scanner: RTL and testbench

//  Row-multiplexing driver for the Pmod Matrix2 LED matrix. Consumes the ~1 kHz scan clock

---
 rtl/matrix_row_scanner_pkg.sv | 14 +
 rtl/matrix_row_scanner_if.sv | 29 ++
 rtl/matrix_row_scanner_rise_detect.sv | 18 +
 rtl/matrix_row_scanner.sv | 132 +++++++++++++
 tb/tb_matrix_row_scanner.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_row_scanner_pkg.sv
// Shared types and default geometry for the LED matrix row scanner.
package matrix_row_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/matrix_row_scanner_if.sv
// Host-side bus of the row scanner: back-buffer write port, swap request and matrix drive outputs.
interface matrix_row_scanner_if
  import matrix_row_scanner_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int RW = $clog2(ROWS);

  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;
  logic            swap_done;

  modport master (
    output wr_en, wr_row, wr_data, swap_req,
    input  row_sel, col_data, frame_start, swap_done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap_req,
    output row_sel, col_data, frame_start, swap_done
  );

endinterface

// File: rtl/matrix_row_scanner_rise_detect.sv
// Rising-edge detector for the scan clock; the output is high for one clk cycle per rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/matrix_row_scanner.sv
// Row-multiplexing driver for an LED matrix with a double-buffered frame and blanking between rows.
// state | meaning
// IDLE  | waiting for the first scan tick after reset
// BLANK | all outputs dark for BLANK_CYCLES; row index advances on the last cycle
// DRIVE | current row driven from the front buffer until the next tick
module matrix_row_scanner
  import matrix_row_scanner_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 scan_clk,
  matrix_row_scanner_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_W   = (RW + 1)'(ROWS);

  scan_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            front_q, front_d;
  logic            pend_q, pend_d;
  logic            do_swap;
  logic            tick;
  logic            wr_ok;
  logic            drive_d;
  logic            frame_start_d;
  logic [ROWS-1:0] row_sel_d;
  logic [COLS-1:0] col_src;
  logic [COLS-1:0] col_data_d;
  logic [COLS-1:0] fb [2][ROWS];

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (scan_clk),
    .rise (tick)
  );

  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_row} < ROWS_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    front_d = front_q;
    do_swap = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = CNT_LOAD;
        end
      end
      BLANK: begin
        // Ticks during blanking are dropped on purpose: no re-arm, no queue.
        if (cnt_q == '0) begin
          state_d = DRIVE;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (pend_q) begin
              do_swap = 1'b1;
              front_d = ~front_q;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request seen in the swap cycle survives the clear and waits for the next frame.
    pend_d = (pend_q & ~do_swap) | bus.swap_req;
  end

  always_comb begin
    drive_d = (state_d == DRIVE);
    col_src = fb[front_d][row_d];
    // A write landing in the buffer that becomes front at this edge must be seen immediately.
    if (wr_ok && (bus.wr_row == row_d) && ((~front_q) == front_d))
      col_src = bus.wr_data;
    row_sel_d     = drive_d ? (ROWS'(1) << row_d) : '0;
    col_data_d    = drive_d ? col_src : '0;
    frame_start_d = (state_q == BLANK) && drive_d && (row_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      row_q           <= ROW_LAST;
      front_q         <= 1'b0;
      pend_q          <= 1'b0;
      bus.row_sel     <= '0;
      bus.col_data    <= '0;
      bus.frame_start <= 1'b0;
      bus.swap_done   <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          fb[b][r] <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      row_q           <= row_d;
      front_q         <= front_d;
      pend_q          <= pend_d;
      bus.row_sel     <= row_sel_d;
      bus.col_data    <= col_data_d;
      bus.frame_start <= frame_start_d;
      bus.swap_done   <= do_swap;
      if (wr_ok)
        fb[~front_q][bus.wr_row] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner: an 8x8 instance for scan/swap/reset and a 6-row instance for write bounds.
module tb_matrix_row_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan8 = 1'b0;
  logic scan6 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  matrix_row_scanner_if #(.ROWS(8), .COLS(8)) bus8 ();
  matrix_row_scanner_if #(.ROWS(6), .COLS(8)) bus6 ();

  matrix_row_scanner #(.ROWS(8), .COLS(8), .BLANK_CYCLES(16)) dut8 (
    .clk(clk), .rst(rst), .scan_clk(scan8), .bus(bus8.slave)
  );

  matrix_row_scanner #(.ROWS(6), .COLS(8), .BLANK_CYCLES(16)) dut6 (
    .clk(clk), .rst(rst), .scan_clk(scan6), .bus(bus6.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drive8(output int cnt);
    cnt = 0;
    while (bus8.row_sel == '0 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  task automatic next_row8();
    int c;
    scan8 = 1'b1;
    step();
    scan8 = 1'b0;
    wait_drive8(c);
    chk("blank_len8", c, 16);
  endtask

  task automatic next_row6();
    int c;
    scan6 = 1'b1;
    step();
    scan6 = 1'b0;
    c = 0;
    while (bus6.row_sel == '0 && c < 40) begin
      c++;
      step();
    end
    chk("blank_len6", c, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus8.wr_en = 1'b0; bus8.wr_row = '0; bus8.wr_data = '0; bus8.swap_req = 1'b0;
    bus6.wr_en = 1'b0; bus6.wr_row = '0; bus6.wr_data = '0; bus6.swap_req = 1'b0;

    // Reset state
    step();
    chk("rst_row_sel", bus8.row_sel, 0);
    chk("rst_col_data", bus8.col_data, 0);
    chk("rst_frame_start", bus8.frame_start, 0);
    chk("rst_swap_done", bus8.swap_done, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_dark", bus8.row_sel, 0);

    // First tick: 16 dark cycles, then row 0 with frame_start
    scan8 = 1'b1;
    step();
    scan8 = 1'b0;
    wait_drive8(n);
    chk("first_blank_len", n, 16);
    chk("first_row_sel", bus8.row_sel, 8'h01);
    chk("first_col_data", bus8.col_data, 8'h00);
    chk("first_frame_start", bus8.frame_start, 1);
    chk("first_swap_done", bus8.swap_done, 0);
    step();
    chk("frame_start_1cyc", bus8.frame_start, 0);
    chk("row0_held", bus8.row_sel, 8'h01);

    // Write back[3]=A5 with a swap request, then walk a frame
    bus8.wr_en = 1'b1; bus8.wr_row = 3'd3; bus8.wr_data = 8'hA5; bus8.swap_req = 1'b1;
    step();
    bus8.wr_en = 1'b0; bus8.swap_req = 1'b0;
    chk("no_direct_front_write", bus8.col_data, 8'h00);
    for (int r = 1; r < 8; r++) begin
      next_row8();
      chk("walk_row_sel", bus8.row_sel, 32'h1 << r);
      chk("walk_pre_swap_col", bus8.col_data, 8'h00);
      chk("walk_no_swap_done", bus8.swap_done, 0);
    end
    next_row8();
    chk("wrap_row_sel", bus8.row_sel, 8'h01);
    chk("wrap_frame_start", bus8.frame_start, 1);
    chk("wrap_swap_done", bus8.swap_done, 1);

    // Swap request and back[0]=3C written in the swap_done cycle
    bus8.wr_en = 1'b1; bus8.wr_row = 3'd0; bus8.wr_data = 8'h3C; bus8.swap_req = 1'b1;
    step();
    bus8.wr_en = 1'b0; bus8.swap_req = 1'b0;
    chk("swap_done_1cyc", bus8.swap_done, 0);
    chk("row0_new_front", bus8.col_data, 8'h00);
    for (int r = 1; r < 8; r++) begin
      next_row8();
      chk("f2_row_sel", bus8.row_sel, 32'h1 << r);
      chk("f2_col_data", bus8.col_data, (r == 3) ? 8'hA5 : 8'h00);
    end
    next_row8();
    chk("second_swap_done", bus8.swap_done, 1);
    chk("second_swap_col", bus8.col_data, 8'h3C);
    step();
    for (int r = 1; r < 8; r++) begin
      next_row8();
      chk("f3_col_data", bus8.col_data, 8'h00);
    end
    next_row8();
    chk("no_third_swap", bus8.swap_done, 0);
    chk("f4_row0_col", bus8.col_data, 8'h3C);
    chk("f4_frame_start", bus8.frame_start, 1);

    // Second tick 10 cycles into BLANK is dropped
    scan8 = 1'b1;
    step();
    scan8 = 1'b0;
    for (int i = 0; i < 9; i++) step();
    scan8 = 1'b1;
    step();
    scan8 = 1'b0;
    wait_drive8(n);
    chk("dropped_tick_blank_rest", n, 6);
    chk("dropped_tick_row", bus8.row_sel, 8'h02);
    for (int i = 0; i < 20; i++) step();
    chk("dropped_tick_stays", bus8.row_sel, 8'h02);

    // Reset in the middle of row 5
    for (int r = 2; r < 6; r++) next_row8();
    chk("row5_sel", bus8.row_sel, 8'h20);
    rst = 1'b1;
    #1;
    chk("midrow_rst_row_sel", bus8.row_sel, 0);
    chk("midrow_rst_col_data", bus8.col_data, 0);
    step();
    step();
    rst = 1'b0;
    step();
    next_row8();
    chk("post_rst_row_sel", bus8.row_sel, 8'h01);
    chk("post_rst_frame_start", bus8.frame_start, 1);
    chk("post_rst_col_cleared", bus8.col_data, 8'h00);

    // 6-row instance: out-of-range writes are ignored
    bus6.wr_en = 1'b1; bus6.wr_row = 3'd7; bus6.wr_data = 8'hFF; bus6.swap_req = 1'b1;
    step();
    bus6.wr_row = 3'd6; bus6.wr_data = 8'hEE; bus6.swap_req = 1'b0;
    step();
    bus6.wr_row = 3'd5; bus6.wr_data = 8'h81;
    step();
    bus6.wr_en = 1'b0;
    next_row6();
    chk("r6_row0_sel", bus6.row_sel, 6'h01);
    chk("r6_swap_done", bus6.swap_done, 1);
    chk("r6_row0_col", bus6.col_data, 8'h00);
    for (int r = 1; r < 6; r++) begin
      next_row6();
      chk("r6_row_sel", bus6.row_sel, 32'h1 << r);
      chk("r6_col_data", bus6.col_data, (r == 5) ? 8'h81 : 8'h00);
    end
    next_row6();
    chk("r6_wrap_sel", bus6.row_sel, 6'h01);
    chk("r6_wrap_frame_start", bus6.frame_start, 1);
    chk("r6_wrap_no_swap", bus6.swap_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
